// File: rtl/riscv_wb_merge_pkg.sv
// Shared writeback definitions: reference entry layout and FIFO pointer sizing.
package riscv_defines;

    // Layout of one buffered long-latency result in the widest (FP-enabled) configuration.
    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
        logic        tag;
        logic        kill;
    } wb_entry_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/riscv_wb_fifo.sv
// In-order result FIFO: always drains its head, and marks older same-address entries as killed.
module riscv_wb_fifo
    import riscv_defines::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push_i,
    input  logic [ADDR_WIDTH-1:0]                 push_addr_i,
    input  logic [DATA_WIDTH-1:0]                 push_data_i,
    input  logic                                  push_tag_i,
    input  logic                                  kill_en_i,
    input  logic [ADDR_WIDTH-1:0]                 kill_addr_i,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic                                  head_valid_o,
    output logic                                  head_kill_o,
    output logic [ADDR_WIDTH-1:0]                 head_addr_o,
    output logic [DATA_WIDTH-1:0]                 head_data_o,
    output logic                                  head_tag_o,
    output logic [DEPTH-1:0]                      live_o,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]      ent_addr_o
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  tag;
        logic                  kill;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          pop;
    logic          push_kill;

    assign empty_o   = (count == '0);
    assign full_o    = (count == FULL_CNT);
    assign pop       = !empty_o;
    // Writes to x0 are dropped, and so is an offered result that a same-cycle execute write supersedes.
    assign push_kill = (push_addr_i == '0) || (kill_en_i && (kill_addr_i == push_addr_i));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_i)
                wr_ptr <= wr_ptr + 1'b1;
            case ({push_i, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The head slot is excluded from kill: it is committing on port B this very cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en_i && (mem[i].addr == kill_addr_i) && (PW'(i) != rd_ptr))
                mem[i].kill <= 1'b1;
        end
        if (push_i)
            mem[wr_ptr] <= '{addr: push_addr_i, data: push_data_i, tag: push_tag_i, kill: push_kill};
    end

    always_comb begin
        logic [PW-1:0] off;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off           = PW'(i) - rd_ptr;
            live_o[i]     = ({1'b0, off} < count) && !mem[i].kill;
            ent_addr_o[i] = mem[i].addr;
        end
    end

    assign head_valid_o = !empty_o;
    assign head_kill_o  = mem[rd_ptr].kill;
    assign head_addr_o  = mem[rd_ptr].addr;
    assign head_data_o  = mem[rd_ptr].data;
    assign head_tag_o   = mem[rd_ptr].tag;

endmodule

// File: rtl/riscv_wb_merge.sv
// Writeback merge: registered execute results on port A, buffered long-latency results on port B.
module riscv_wb_merge
    import riscv_defines::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ex_we_i,
    input  logic [ADDR_WIDTH-1:0]         ex_waddr_i,
    input  logic [DATA_WIDTH-1:0]         ex_wdata_i,
    input  logic                          ex_wtag_i,
    input  logic                          lsu_valid_i,
    output logic                          lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0]         lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]         lsu_wdata_i,
    input  logic                          lsu_wtag_i,
    output logic                          rf_we_a_o,
    output logic [ADDR_WIDTH-1:0]         rf_waddr_a_o,
    output logic [DATA_WIDTH-1:0]         rf_wdata_a_o,
    output logic                          rf_wtag_a_o,
    output logic                          rf_we_b_o,
    output logic [ADDR_WIDTH-1:0]         rf_waddr_b_o,
    output logic [DATA_WIDTH-1:0]         rf_wdata_b_o,
    output logic                          rf_wtag_b_o,
    output logic [(1<<ADDR_WIDTH)-1:0]    pending_o,
    output logic                          empty_o
);

    logic                             full;
    logic                             push;
    logic                             kill_en;
    logic                             head_valid;
    logic                             head_kill;
    logic [DEPTH-1:0]                 live;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;

    assign lsu_ready_o = !full;
    assign push        = lsu_valid_i && lsu_ready_o;
    assign kill_en     = ex_we_i && (ex_waddr_i != '0);

    riscv_wb_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_addr_i  (lsu_waddr_i),
        .push_data_i  (lsu_wdata_i),
        .push_tag_i   (lsu_wtag_i),
        .kill_en_i    (kill_en),
        .kill_addr_i  (ex_waddr_i),
        .full_o       (full),
        .empty_o      (empty_o),
        .head_valid_o (head_valid),
        .head_kill_o  (head_kill),
        .head_addr_o  (rf_waddr_b_o),
        .head_data_o  (rf_wdata_b_o),
        .head_tag_o   (rf_wtag_b_o),
        .live_o       (live),
        .ent_addr_o   (ent_addr)
    );

    // Port A: one register stage, so an execute write lands one cycle after any B write it races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_a_o    <= 1'b0;
            rf_waddr_a_o <= '0;
            rf_wdata_a_o <= '0;
            rf_wtag_a_o  <= 1'b0;
        end else begin
            rf_we_a_o    <= ex_we_i;
            rf_waddr_a_o <= ex_waddr_i;
            rf_wdata_a_o <= ex_wdata_i;
            rf_wtag_a_o  <= ex_wtag_i;
        end
    end

    assign rf_we_b_o = head_valid && !head_kill;

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i])
                pending_o[ent_addr[i]] = 1'b1;
        end
        pending_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_riscv_wb_merge.sv
// Self-checking bench for riscv_wb_merge against a queue-based model of the writeback rules.
module tb_riscv_wb_merge;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic               clk;
    logic               rst_n;
    logic               ex_we;
    logic [AW-1:0]      ex_waddr;
    logic [DW-1:0]      ex_wdata;
    logic               ex_wtag;
    logic               lsu_valid;
    logic               lsu_ready;
    logic [AW-1:0]      lsu_waddr;
    logic [DW-1:0]      lsu_wdata;
    logic               lsu_wtag;
    logic               rf_we_a, rf_we_b, rf_wtag_a, rf_wtag_b;
    logic [AW-1:0]      rf_waddr_a, rf_waddr_b;
    logic [DW-1:0]      rf_wdata_a, rf_wdata_b;
    logic [(1<<AW)-1:0] pending;
    logic               empty;

    riscv_wb_merge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_we_i      (ex_we),
        .ex_waddr_i   (ex_waddr),
        .ex_wdata_i   (ex_wdata),
        .ex_wtag_i    (ex_wtag),
        .lsu_valid_i  (lsu_valid),
        .lsu_ready_o  (lsu_ready),
        .lsu_waddr_i  (lsu_waddr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_wtag_i   (lsu_wtag),
        .rf_we_a_o    (rf_we_a),
        .rf_waddr_a_o (rf_waddr_a),
        .rf_wdata_a_o (rf_wdata_a),
        .rf_wtag_a_o  (rf_wtag_a),
        .rf_we_b_o    (rf_we_b),
        .rf_waddr_b_o (rf_waddr_b),
        .rf_wdata_b_o (rf_wdata_b),
        .rf_wtag_b_o  (rf_wtag_b),
        .pending_o    (pending),
        .empty_o      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          tag;
        logic          kill;
    } m_ent_t;

    m_ent_t        mq[$];
    logic          ma_we;
    logic [AW-1:0] ma_addr;
    logic [DW-1:0] ma_data;
    logic          ma_tag;
    int            checks = 0;
    int            fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [(1<<AW)-1:0] exp_pend;
        logic               exp_web;
        exp_pend = '0;
        foreach (mq[i])
            if (!mq[i].kill && mq[i].addr != 0)
                exp_pend[mq[i].addr] = 1'b1;
        exp_web = 1'b0;
        if (mq.size() > 0)
            exp_web = !mq[0].kill;
        chk("empty",   empty,     mq.size() == 0);
        chk("ready",   lsu_ready, mq.size() != DEPTH);
        chk("pending", pending,   exp_pend);
        chk("we_a",    rf_we_a,   ma_we);
        chk("waddr_a", rf_waddr_a, ma_addr);
        chk("wdata_a", rf_wdata_a, ma_data);
        chk("wtag_a",  rf_wtag_a, ma_tag);
        chk("we_b",    rf_we_b,   exp_web);
        if (exp_web) begin
            chk("waddr_b", rf_waddr_b, mq[0].addr);
            chk("wdata_b", rf_wdata_b, mq[0].data);
            chk("wtag_b",  rf_wtag_b,  mq[0].tag);
        end
    endtask

    // Advance one clock: apply the writeback rules to the model, then compare.
    task automatic step();
        m_ent_t e;
        logic   do_push;
        logic   ex_kill;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            ma_we = 0; ma_addr = '0; ma_data = '0; ma_tag = 0;
        end else begin
            do_push = lsu_valid && (mq.size() != DEPTH);
            ex_kill = ex_we && (ex_waddr != 0);
            for (int i = 1; i < mq.size(); i++)
                if (ex_kill && mq[i].addr == ex_waddr)
                    mq[i].kill = 1'b1;
            if (mq.size() > 0)
                void'(mq.pop_front());
            if (do_push) begin
                e.addr = lsu_waddr;
                e.data = lsu_wdata;
                e.tag  = lsu_wtag;
                e.kill = (lsu_waddr == 0) || (ex_kill && ex_waddr == lsu_waddr);
                mq.push_back(e);
            end
            ma_we = ex_we; ma_addr = ex_waddr; ma_data = ex_wdata; ma_tag = ex_wtag;
        end
        #1;
        check_all();
    endtask

    task automatic set_ex(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic t);
        ex_we = we; ex_waddr = a; ex_wdata = d; ex_wtag = t;
    endtask

    task automatic set_lsu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic t);
        lsu_valid = v; lsu_waddr = a; lsu_wdata = d; lsu_wtag = t;
    endtask

    initial begin
        int sent;
        rst_n = 0;
        set_ex(0, 0, 0, 0);
        set_lsu(0, 0, 0, 0);
        ma_we = 0; ma_addr = '0; ma_data = '0; ma_tag = 0;
        step();
        step();
        rst_n = 1;
        step();

        // Throughput: x5 pushed, on port B next cycle with pending bit for that cycle only
        set_lsu(1, 5, 32'hA, 1);
        step();
        set_lsu(0, 0, 0, 0);
        chk("thr_we_b",   rf_we_b, 1);
        chk("thr_addr_b", rf_waddr_b, 5);
        chk("thr_data_b", rf_wdata_b, 32'hA);
        chk("thr_pend5",  pending[5], 1);
        step();
        chk("thr_pend5_clr", pending[5], 0);

        // Stream of three results under a continuously asserted valid
        sent = 0;
        for (int c = 0; c < 10 && sent < 3; c++) begin
            set_lsu(1, AW'(10 + sent), 32'h100 + sent, sent[0]);
            if (mq.size() != DEPTH) sent++;
            step();
        end
        set_lsu(0, 0, 0, 0);
        chk("bp_all_sent", sent, 3);
        step();
        step();

        // Ex write to x7 while an older x7 sits at the head: B commits first, A follows
        set_lsu(1, 7, 32'h1, 0);
        step();
        set_lsu(0, 0, 0, 0);
        set_ex(1, 7, 32'h2, 1);
        step();
        set_ex(0, 0, 0, 0);
        chk("waw_a_data", rf_wdata_a, 32'h2);
        step();

        // Concurrent push and ex write to x9: the pushed entry is dead on arrival
        set_lsu(1, 9, 32'h99, 1);
        set_ex(1, 9, 32'h55, 0);
        step();
        set_lsu(0, 0, 0, 0);
        set_ex(0, 0, 0, 0);
        chk("cc_we_b",   rf_we_b, 0);
        chk("cc_pend9",  pending[9], 0);
        chk("cc_we_a",   rf_we_a, 1);
        step();

        // Push to x0: accepted, never written, drains in one cycle
        set_lsu(1, 0, 32'hDEAD, 1);
        step();
        set_lsu(0, 0, 0, 0);
        chk("x0_empty", empty, 0);
        chk("x0_we_b",  rf_we_b, 0);
        step();
        chk("x0_empty_back", empty, 1);

        // Reset mid-operation with valid still offered
        set_lsu(1, 12, 32'h77, 0);
        step();
        rst_n = 0;
        step();
        chk("rst_empty", empty, 1);
        chk("rst_pend",  pending, 0);
        rst_n = 1;
        set_lsu(0, 0, 0, 0);
        step();
        chk("rst_no_we_b", rf_we_b, 0);

        // Randomized traffic with clustered addresses to provoke collisions
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            set_ex($urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3)),
                   $urandom, $urandom_range(0, 1));
            set_lsu($urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3)),
                    $urandom, $urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
